// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-port synchronous-read memory between fetch and data ports.
// Optional performance counters are enabled by defining ARB_PERF_CNT_EN.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [31:0]       i_rdata,
  input  logic              d_req,
  input  logic [3:0]        d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              m_en,
  output logic [3:0]        m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [31:0]       m_wdata,
  input  logic [31:0]       m_rdata
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]       perf_i_stall,
  output logic [31:0]       perf_d_acc
`endif
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_I    = 2'd1;
  localparam logic [1:0] OWN_D    = 2'd2;

  logic [3:0] starve_cnt;
  logic [1:0] rd_owner;

  // Data wins unless fetch has been denied STARVE_LIMIT cycles in a row.
  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (!reset) begin
      if (i_req && (!d_req || starve_cnt == LIMIT)) begin
        i_gnt = 1'b1;
      end else if (d_req) begin
        d_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    m_en    = i_gnt | d_gnt;
    m_we    = d_gnt ? d_we : '0;
    m_addr  = d_gnt ? d_addr : (i_gnt ? i_addr : '0);
    m_wdata = d_gnt ? d_wdata : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
      rd_owner   <= OWN_NONE;
    end else begin
      if (i_req && !i_gnt) begin
        starve_cnt <= (starve_cnt == LIMIT) ? starve_cnt : starve_cnt + 4'd1;
      end else begin
        starve_cnt <= '0;
      end
      if (i_gnt) begin
        rd_owner <= OWN_I;
      end else if (d_gnt && d_we == 4'b0000) begin
        rd_owner <= OWN_D;
      end else begin
        rd_owner <= OWN_NONE;
      end
    end
  end

  // Gating on reset drops a return that was in flight when reset arrived.
  always_comb begin
    i_rvalid = !reset && (rd_owner == OWN_I);
    d_rvalid = !reset && (rd_owner == OWN_D);
    i_rdata  = i_rvalid ? m_rdata : '0;
    d_rdata  = d_rvalid ? m_rdata : '0;
  end

`ifdef ARB_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_i_stall <= '0;
      perf_d_acc   <= '0;
    end else begin
      if (i_req && !i_gnt) begin
        perf_i_stall <= perf_i_stall + 32'd1;
      end
      if (d_gnt) begin
        perf_d_acc <= perf_d_acc + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed plus randomized bench for mem_port_arbiter with a behavioural memory
// and a cycle-level reference model of grant, starvation and read-return rules.
module tb_mem_port_arbiter;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt, i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req;
  logic [3:0]  d_we;
  logic [31:0] d_addr, d_wdata;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic        m_en;
  logic [3:0]  m_we;
  logic [31:0] m_addr, m_wdata;
  logic [31:0] m_rdata;
`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_i_stall, perf_d_acc;
  logic [31:0] exp_stall, exp_dacc;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          iwait;
  int          pend;       // 0 none, 1 fetch, 2 data
  logic [31:0] pend_data;
  logic        last_ig, last_dg;

  mem_port_arbiter #(.ADDR_W(32), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
`ifdef ARB_PERF_CNT_EN
    , .perf_i_stall(perf_i_stall), .perf_d_acc(perf_d_acc)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural memory macro: synchronous read, byte-enabled write, garbage when idle.
  logic [31:0] mem [0:1023];
  logic        loaded = 1'b0;
  always @(posedge clk) begin
    if (!loaded) begin
      for (int k = 0; k < 1024; k++)
        mem[k] <= (k == 128) ? 32'h1234_5678 : 32'hA000_0000 + 32'(k);
      loaded <= 1'b1;
    end else if (m_en && m_we == 4'b0000) begin
      m_rdata <= mem[m_addr[11:2]];
    end else begin
      if (m_en) begin
        for (int b = 0; b < 4; b++)
          if (m_we[b]) mem[m_addr[11:2]][8*b +: 8] <= m_wdata[8*b +: 8];
      end
      m_rdata <= $urandom;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check one cycle against the model, then advance to the next negedge.
  task automatic cycle();
    logic eig, edg;
    #1;
    if (reset) begin
      eig = 1'b0;
      edg = 1'b0;
    end else begin
      eig = i_req && (!d_req || iwait == LIMIT);
      edg = d_req && !eig;
    end
    chk("i_gnt", {63'b0, i_gnt}, {63'b0, eig});
    chk("d_gnt", {63'b0, d_gnt}, {63'b0, edg});
    chk("m_en", {63'b0, m_en}, {63'b0, eig || edg});
    chk("m_we", {60'b0, m_we}, edg ? {60'b0, d_we} : 64'd0);
    if (eig || edg) begin
      chk("m_addr", {32'b0, m_addr}, edg ? {32'b0, d_addr} : {32'b0, i_addr});
      chk("m_wdata", {32'b0, m_wdata}, edg ? {32'b0, d_wdata} : 64'd0);
    end
    chk("i_rvalid", {63'b0, i_rvalid}, {63'b0, !reset && pend == 1});
    chk("d_rvalid", {63'b0, d_rvalid}, {63'b0, !reset && pend == 2});
    chk("i_rdata", {32'b0, i_rdata}, (!reset && pend == 1) ? {32'b0, pend_data} : 64'd0);
    chk("d_rdata", {32'b0, d_rdata}, (!reset && pend == 2) ? {32'b0, pend_data} : 64'd0);
`ifdef ARB_PERF_CNT_EN
    chk("perf_i_stall", {32'b0, perf_i_stall}, {32'b0, exp_stall});
    chk("perf_d_acc", {32'b0, perf_d_acc}, {32'b0, exp_dacc});
`endif
    if (reset) begin
      iwait = 0;
      pend  = 0;
`ifdef ARB_PERF_CNT_EN
      exp_stall = 0;
      exp_dacc  = 0;
`endif
    end else begin
      iwait = (i_req && !eig) ? ((iwait + 1 > LIMIT) ? LIMIT : iwait + 1) : 0;
      pend  = eig ? 1 : ((edg && d_we == 4'b0000) ? 2 : 0);
      pend_data = eig ? mem[i_addr[11:2]] : mem[d_addr[11:2]];
`ifdef ARB_PERF_CNT_EN
      if (i_req && !eig) exp_stall = exp_stall + 1;
      if (edg) exp_dacc = exp_dacc + 1;
`endif
    end
    last_ig = eig;
    last_dg = edg;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    iwait = 0; pend = 0; pend_data = '0; last_ig = 0; last_dg = 0;
`ifdef ARB_PERF_CNT_EN
    exp_stall = 0; exp_dacc = 0;
`endif
    reset = 1'b1;
    i_req = 0; i_addr = '0; d_req = 0; d_we = '0; d_addr = '0; d_wdata = '0;
    @(negedge clk);
    cycle();
    i_req = 1; d_req = 1;          // requests must be ignored while in reset
    cycle();
    reset = 1'b0;
    i_req = 0; d_req = 0;
    cycle();

    // Fetch only, back-to-back
    i_req = 1; i_addr = 32'h0;
    cycle();
    i_addr = 32'h4;
    cycle();
    i_req = 0;
    #1 chk("fetch_rdata_0x4", {32'b0, i_rdata}, 64'hA000_0001);
    cycle();

    // Contention: data wins first, fetch follows
    i_req = 1; i_addr = 32'h40; d_req = 1; d_we = 4'b0000; d_addr = 32'h100;
    #1 chk("contention_d_first", {63'b0, d_gnt}, 64'd1);
    cycle();
    d_req = 0;
    #1 chk("contention_d_rdata", {32'b0, d_rdata}, 64'hA000_0040);
    cycle();
    i_req = 0;
    cycle();

    // Starvation: d_req held 10 cycles, fetch forced on its 5th cycle
    reset = 1; cycle(); reset = 0;
    i_req = 1; i_addr = 32'h80; d_req = 1; d_we = 4'b0000; d_addr = 32'h300;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (k < 4) chk("starve_fetch_denied", {63'b0, i_gnt}, 64'd0);
      if (k == 4) chk("starve_fetch_wins", {62'b0, i_gnt, d_gnt}, 64'd2);
      cycle();
      if (last_ig) i_req = 0;
      d_addr = d_addr + 32'h4;
    end
    d_req = 0;
`ifdef ARB_PERF_CNT_EN
    #1;
    chk("perf_i_stall_end", {32'b0, perf_i_stall}, 64'd4);
    chk("perf_d_acc_end", {32'b0, perf_d_acc}, 64'd9);
`endif
    cycle();

    // Store with partial byte enables, then read it back
    d_req = 1; d_we = 4'b0011; d_addr = 32'h200; d_wdata = 32'hDEAD_BEEF;
    cycle();
    d_we = 4'b0000;
    #1 chk("store_no_rvalid", {63'b0, d_rvalid}, 64'd0);
    cycle();
    d_req = 0;
    #1 chk("store_merge", {32'b0, d_rdata}, 64'h1234_BEEF);
    cycle();

    // Reset in the cycle after a fetch grant
    i_req = 1; i_addr = 32'h10;
    cycle();
    reset = 1; i_req = 1; d_req = 1;
    #1 chk("reset_drop_rvalid", {63'b0, i_rvalid}, 64'd0);
    cycle();
    reset = 0;
    cycle();   // both requesting: counter restarted, so data must win
    i_req = 0; d_req = 0;
    cycle();

    // Randomized traffic with hold-until-grant requesters
    for (int n = 0; n < 400; n++) begin
      if (last_ig || !i_req) begin
        i_req  = ($urandom % 3) != 0;
        i_addr = {20'b0, 10'($urandom), 2'b00};
      end else if ($urandom % 16 == 0) begin
        i_req = 0;
      end
      if (last_dg || !d_req) begin
        d_req   = ($urandom % 4) != 0;
        d_addr  = {20'b0, 10'($urandom), 2'b00};
        d_we    = ($urandom % 2 == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
        d_wdata = $urandom;
      end else if ($urandom % 16 == 0) begin
        d_req = 0;
      end
      reset = ($urandom % 64) == 0;
      cycle();
      reset = 0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates one single-port, synchronous-read unified memory between the pipelined core's instruction-fetch port and data port. It sits between the core and the memory macro, grants at most one access per cycle, and routes read data back to the owning requester one cycle later. A starvation counter bounds fetch latency under sustained data traffic.

## Interface
Parameters:
- ADDR_W, 32, address width for both requesters and memory
- STARVE_LIMIT, 4, consecutive denied fetch cycles before fetch is forced to win (1..15)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- i_req  in  1  fetch request; held until i_gnt
- i_addr  in  ADDR_W  fetch byte address
- i_gnt  out  1  fetch accepted this cycle
- i_rvalid  out  1  i_rdata valid (cycle after i_gnt)
- i_rdata  out  32  fetched instruction
- d_req  in  1  data request; held until d_gnt
- d_we  in  4  byte write enables; 0 = read
- d_addr  in  ADDR_W  data byte address
- d_wdata  in  32  store data
- d_gnt  out  1  data access accepted this cycle
- d_rvalid  out  1  d_rdata valid (cycle after a granted read)
- d_rdata  out  32  load data
- m_en  out  1  memory access strobe
- m_we  out  4  memory byte write enables
- m_addr  out  ADDR_W  memory address
- m_wdata  out  32  memory write data
- m_rdata  in  32  memory read data, valid one cycle after m_en with m_we=0

## Operation
- Combinational grant: at most one of i_gnt/d_gnt high per cycle; gnt only asserted when corresponding req high.
- Priority: data wins by default; fetch wins when starve_cnt == STARVE_LIMIT and i_req high.
- On grant, m_en=1, m_addr/m_we/m_wdata driven from winner; fetch grant drives m_we=0, m_wdata=0. No grant: m_en=0, m_we=0.
- starve_cnt (4-bit): +1 when i_req && !i_gnt, saturating at STARVE_LIMIT; cleared when i_gnt or !i_req.
- Return tracking: register rd_owner {NONE, I, D} captured each cycle: I on i_gnt, D on d_gnt with d_we==0, else NONE.
- Cycle after grant: rd_owner=I -> i_rvalid=1, i_rdata=m_rdata; rd_owner=D -> d_rvalid=1, d_rdata=m_rdata. Non-owner rvalid=0, rdata=0.
- Writes (d_we!=0) produce no rvalid.
- Back-to-back grants allowed every cycle; return of cycle N overlaps grant of cycle N+1.

## Timing
- Grant latency 0 cycles (same cycle as req if winning); read-data latency exactly 1 cycle after gnt.
- Reset values: rd_owner=NONE, starve_cnt=0, i_rvalid=d_rvalid=0, i_rdata=d_rdata=0; gnt/m_* outputs 0 while reset high regardless of req.
- Reset asserted in the cycle after a grant: pending rvalid suppressed, data discarded.
- Simultaneous i_req and d_req with starve_cnt<STARVE_LIMIT: d_gnt=1, i_gnt=0, counter increments.
- Requester dropping req before gnt is permitted; no state retained for it.
- Max fetch wait under continuous d_req: STARVE_LIMIT cycles, then granted on cycle STARVE_LIMIT+1.

## Configuration
- ARB_PERF_CNT_EN defined: adds outputs perf_i_stall (32-bit, cycles with i_req && !i_gnt) and perf_d_acc (32-bit, count of d_gnt); both reset to 0, wrap at 2^32.
- Undefined: ports and counters absent; arbitration behaviour identical.

## Test plan
- Fetch only: i_req=1 addr 0x0, 0x4 consecutive -> i_gnt each cycle, i_rvalid next cycles with mem contents of 0x0, 0x4; d_* quiet.
- Contention: i_req and d_req(read 0x100) same cycle, starve_cnt=0 -> d_gnt=1, i_gnt=0, d_rvalid next cycle with mem[0x100], i_gnt following cycle.
- Starvation: d_req held high 10 cycles, i_req high, STARVE_LIMIT=4 -> i_gnt on 5th cycle, d_gnt low that cycle, counter back to 0.
- Store: d_req, d_we=4'b0011, addr 0x200, wdata 0xDEADBEEF -> m_we=0011 same cycle, no d_rvalid; later read returns low halfword 0xBEEF merged.
- Reset mid-read: i_gnt at cycle N, reset high at N+1 -> i_rvalid=0 at N+1, all outputs 0, starve_cnt=0.
- ARB_PERF_CNT_EN: starvation scenario -> perf_i_stall=4, perf_d_acc=9 at end.
